// File: rtl/sound_sequencer.sv
// sound_sequencer: queues per-player bomb sound requests and hands them to the sample
// player one trigger at a time. Optional `SND_PRIORITY_EN: explosions served ahead of ticks.
module sound_sequencer #(
    parameter int NB_PLAYERS  = 2,
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                         clk_50,
    input  logic                         reset,
    input  logic [NB_PLAYERS-1:0]        tictac_req,
    input  logic [NB_PLAYERS-1:0]        explosion_req,
    input  logic                         snd_busy,
    output logic                         tictac,
    output logic                         explosion,
    output logic [$clog2(DEPTH+1)-1:0]   pending,
    output logic                         overflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, PLAY} state_t;

    state_t           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tictac_d, explosion_d;
    logic             pop, have_entry, head_expl, drop;
    logic             expl_in, tick_in;

    // Several players requesting the same sound in one cycle collapse to one entry
    assign expl_in = |explosion_req;
    assign tick_in = |tictac_req;

`ifndef SND_PRIORITY_EN
    logic [DEPTH-1:0] fifo_mem;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, tail_ptr, tick_ptr;
    logic [CNT_W-1:0] fifo_cnt_q, cnt_pop, cnt_mid, cnt_d;
    logic             wr_expl, wr_tick, newest_tick;

    assign have_entry = (fifo_cnt_q != '0);
    assign head_expl  = fifo_mem[rd_ptr_q];
    assign tail_ptr   = wr_ptr_q - PTR_W'(1);
    assign tick_ptr   = wr_ptr_q + PTR_W'(wr_expl);

    // Pop first, then EXPL, then TICK; the TICK coalesces against whatever is newest
    always_comb begin
        cnt_pop     = fifo_cnt_q - CNT_W'(pop);
        wr_expl     = expl_in && (cnt_pop < DEPTH_C);
        cnt_mid     = cnt_pop + CNT_W'(wr_expl);
        newest_tick = !wr_expl && (cnt_pop != '0) && !fifo_mem[tail_ptr];
        wr_tick     = tick_in && !newest_tick && (cnt_mid < DEPTH_C);
        drop        = (expl_in && !wr_expl) || (tick_in && !newest_tick && !wr_tick);
        cnt_d       = cnt_mid + CNT_W'(wr_tick);
    end

    always_ff @(posedge clk_50) begin
        if (wr_expl) fifo_mem[wr_ptr_q] <= 1'b1;
        if (wr_tick) fifo_mem[tick_ptr] <= 1'b0;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + PTR_W'(wr_expl) + PTR_W'(wr_tick);
            rd_ptr_q   <= rd_ptr_q + PTR_W'(pop);
            fifo_cnt_q <= cnt_d;
        end
    end

    assign pending = fifo_cnt_q;
`else
    logic [CNT_W-1:0] tick_cnt_q, expl_cnt_q, tick_pop, expl_pop, tick_cnt_d, expl_cnt_d;
    logic             tick_last_q, tick_last_d, newest_tick, tick_want;
    logic [CNT_W:0]   pend_sum;

    assign have_entry = (tick_cnt_q != '0) || (expl_cnt_q != '0);
    assign head_expl  = (expl_cnt_q != '0);

    // Ticks are all identical, so both queues reduce to counters; tick_last tracks arrival order
    always_comb begin
        tick_pop    = tick_cnt_q - CNT_W'(pop && !head_expl);
        expl_pop    = expl_cnt_q - CNT_W'(pop && head_expl);
        newest_tick = (tick_pop != '0) && (tick_last_q || (expl_pop == '0));
        expl_cnt_d  = expl_pop;
        tick_cnt_d  = tick_pop;
        tick_last_d = tick_last_q;
        drop        = 1'b0;
        if (expl_in) begin
            if (expl_pop < DEPTH_C) begin
                expl_cnt_d  = expl_pop + CNT_W'(1);
                tick_last_d = 1'b0;
                newest_tick = 1'b0;
            end else begin
                drop = 1'b1;
            end
        end
        tick_want = tick_in && !newest_tick;
        if (tick_want) begin
            if (tick_pop < DEPTH_C) begin
                tick_cnt_d  = tick_pop + CNT_W'(1);
                tick_last_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end
        pend_sum = {1'b0, tick_cnt_q} + {1'b0, expl_cnt_q};
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            tick_cnt_q  <= '0;
            expl_cnt_q  <= '0;
            tick_last_q <= 1'b0;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            expl_cnt_q  <= expl_cnt_d;
            tick_last_q <= tick_last_d;
        end
    end

    assign pending = (pend_sum > {1'b0, DEPTH_C}) ? DEPTH_C : pend_sum[CNT_W-1:0];
`endif

    // Trigger is registered together with the move into FIRE, so it is high exactly in FIRE
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        tictac_d    = 1'b0;
        explosion_d = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (have_entry && !snd_busy) begin
                    pop         = 1'b1;
                    state_d     = FIRE;
                    explosion_d = head_expl;
                    tictac_d    = !head_expl;
                end
            end
            FIRE: begin
                state_d = WAIT_ACK;
                tmo_d   = '0;
            end
            WAIT_ACK: begin
                if (snd_busy) begin
                    state_d = PLAY;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            PLAY: begin
                if (!snd_busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            tictac    <= 1'b0;
            explosion <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            tictac    <= tictac_d;
            explosion <= explosion_d;
            overflow  <= overflow | drop;
        end
    end

endmodule
